// File: rtl/pipe_hazard_if.sv
// Decode-side bundle between the ID stage and the hazard/forwarding controller.
// The master modport is the decode stage. The slave modport is the hazard unit.
interface pipe_hazard_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int RD_PORTS       = 2,
    parameter int SEL_WIDTH      = 2,
    parameter int STAT_WIDTH     = 16
);
    logic                               id_valid;
    logic [RD_PORTS*REG_ADDR_WIDTH-1:0] id_rr;
    logic [RD_PORTS-1:0]                id_rr_used;
    logic                               id_regWrite;
    logic [REG_ADDR_WIDTH-1:0]          id_regToWrite;
    logic                               id_memRead;
    logic                               id_branch;
    logic                               id_redirect;
    logic                               stall;
    logic                               flush_id;
    logic [RD_PORTS*SEL_WIDTH-1:0]      fwd_sel;
    logic [STAT_WIDTH-1:0]              stall_count;
    logic [STAT_WIDTH-1:0]              fwd_count;

    modport master (
        output id_valid, id_rr, id_rr_used, id_regWrite, id_regToWrite,
               id_memRead, id_branch, id_redirect,
        input  stall, flush_id, fwd_sel, stall_count, fwd_count
    );

    modport slave (
        input  id_valid, id_rr, id_rr_used, id_regWrite, id_regToWrite,
               id_memRead, id_branch, id_redirect,
        output stall, flush_id, fwd_sel, stall_count, fwd_count
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for a 5-stage MIPS pipeline.
// It keeps a shift-register scoreboard of in-flight writes and produces stall, flush and forward selects.
module pipe_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int RD_PORTS       = 2,
    parameter int FWD_STAGES     = 3,
    parameter int SEL_WIDTH      = 2,
    parameter int LOAD_READY     = 2,
    parameter int ALU_READY      = 1,
    parameter int STAT_WIDTH     = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int W = REG_ADDR_WIDTH;

    logic [FWD_STAGES-1:0]              sb_valid_r;
    logic [FWD_STAGES-1:0]              sb_load_r;
    logic [FWD_STAGES-1:0][W-1:0]       sb_rd_r;
    logic [RD_PORTS-1:0][SEL_WIDTH-1:0] win_sel_s;
    logic [RD_PORTS-1:0]                found_s;
    logic                               hazard_s;
    logic                               stall_s;
    logic                               flush_s;
    logic                               fwd_any_s;
    logic [RD_PORTS*SEL_WIDTH-1:0]      fwd_sel_s;
    logic [STAT_WIDTH-1:0]              stall_count_r;
    logic [STAT_WIDTH-1:0]              fwd_count_r;

    // Per-port youngest-first match search and hazard classification of the winner.
    always_comb begin
        win_sel_s = '0;
        found_s   = '0;
        hazard_s  = 1'b0;
        for (int p = 0; p < RD_PORTS; p++) begin
            for (int i = 0; i < FWD_STAGES; i++) begin
                if (!found_s[p] && hz.id_rr_used[p] && (hz.id_rr[p*W +: W] != '0) &&
                    sb_valid_r[i] && (sb_rd_r[i] == hz.id_rr[p*W +: W])) begin
                    found_s[p]   = 1'b1;
                    win_sel_s[p] = SEL_WIDTH'(i + 1);
                    if ((sb_load_r[i] && (i < LOAD_READY)) || (hz.id_branch && (i < ALU_READY))) begin
                        hazard_s = 1'b1;
                    end else begin
                        hazard_s = hazard_s;
                    end
                end else begin
                    found_s[p] = found_s[p];
                end
            end
        end
    end

    // Reset and an empty ID slot silence everything; a stall wins over forwarding and flush.
    always_comb begin
        stall_s   = 1'b0;
        fwd_sel_s = '0;
        flush_s   = 1'b0;
        if (rst || !hz.id_valid) begin
            stall_s   = 1'b0;
            fwd_sel_s = '0;
            flush_s   = 1'b0;
        end else begin
            stall_s   = hazard_s;
            fwd_sel_s = hazard_s ? '0 : win_sel_s;
            flush_s   = hz.id_redirect & ~hazard_s;
        end
    end

    assign fwd_any_s = |fwd_sel_s;

    // Scoreboard shift: a stalled or non-writing ID slot enters EX as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_r <= '0;
            sb_load_r  <= '0;
            sb_rd_r    <= '0;
        end else begin
            for (int i = 1; i < FWD_STAGES; i++) begin
                sb_valid_r[i] <= sb_valid_r[i-1];
                sb_load_r[i]  <= sb_load_r[i-1];
                sb_rd_r[i]    <= sb_rd_r[i-1];
            end
            sb_valid_r[0] <= hz.id_valid & hz.id_regWrite & (hz.id_regToWrite != '0) & ~stall_s;
            sb_load_r[0]  <= hz.id_memRead;
            sb_rd_r[0]    <= hz.id_regToWrite;
        end
    end

    // Saturating event counters for stall and forwarding cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= '0;
            fwd_count_r   <= '0;
        end else begin
            if (stall_s && (stall_count_r != '1)) begin
                stall_count_r <= stall_count_r + 1'b1;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (fwd_any_s && (fwd_count_r != '1)) begin
                fwd_count_r <= fwd_count_r + 1'b1;
            end else begin
                fwd_count_r <= fwd_count_r;
            end
        end
    end

    assign hz.stall       = stall_s;
    assign hz.flush_id    = flush_s;
    assign hz.fwd_sel     = fwd_sel_s;
    assign hz.stall_count = stall_count_r;
    assign hz.fwd_count   = fwd_count_r;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed pipeline scenarios plus random decode traffic.
// A queue-based reference model feeds a scoreboard that a negedge monitor drains.
module tb_pipe_hazard_unit;
    localparam int W  = 5;
    localparam int RP = 2;
    localparam int SW = 2;
    localparam int LR = 2;
    localparam int AR = 1;
    localparam int FS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_if #(.REG_ADDR_WIDTH(W), .RD_PORTS(RP), .SEL_WIDTH(SW), .STAT_WIDTH(16)) hif ();
    pipe_hazard_if #(.REG_ADDR_WIDTH(W), .RD_PORTS(RP), .SEL_WIDTH(SW), .STAT_WIDTH(4))  hsat ();

    assign hsat.id_valid      = hif.id_valid;
    assign hsat.id_rr         = hif.id_rr;
    assign hsat.id_rr_used    = hif.id_rr_used;
    assign hsat.id_regWrite   = hif.id_regWrite;
    assign hsat.id_regToWrite = hif.id_regToWrite;
    assign hsat.id_memRead    = hif.id_memRead;
    assign hsat.id_branch     = hif.id_branch;
    assign hsat.id_redirect   = hif.id_redirect;

    pipe_hazard_unit #(.STAT_WIDTH(16)) dut     (.clk(clk), .rst(rst), .hz(hif));
    pipe_hazard_unit #(.STAT_WIDTH(4))  dut_sat (.clk(clk), .rst(rst), .hz(hsat));

    typedef struct {
        logic       stall;
        logic       flush;
        logic [3:0] fwd;
        int         sc;
        int         fc;
        int         ssc;
        int         sfc;
    } exp_t;

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;

    exp_t expq[$];
    exp_t me;
    ent_t infl[$];
    int   stall_ev = 0;
    int   fwd_ev = 0;
    bit   last_stall = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    bit       hr, hv, hrw, hld, hbr, hred;
    int       ha0, ha1, hrd;
    bit [1:0] hu;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Drive one ID cycle, predict the response from the in-flight list, then advance the model.
    task automatic apply(input bit r, input bit v, input int a0, input int a1, input bit [1:0] used,
                         input bit rw, input int rd, input bit ld, input bit br, input bit redir);
        exp_t e;
        ent_t n;
        int   win[2];
        int   rr;
        bit   haz;
        @(posedge clk);
        #1;
        rst               = r;
        hif.id_valid      = v;
        hif.id_rr         = {5'(a1), 5'(a0)};
        hif.id_rr_used    = used;
        hif.id_regWrite   = rw;
        hif.id_regToWrite = 5'(rd);
        hif.id_memRead    = ld;
        hif.id_branch     = br;
        hif.id_redirect   = redir;
        haz = 1'b0;
        for (int p = 0; p < RP; p++) begin
            rr     = (p == 0) ? a0 : a1;
            win[p] = -1;
            if (used[p] && rr != 0) begin
                for (int i = 0; i < infl.size(); i++) begin
                    if (win[p] < 0 && infl[i].v && infl[i].rd == rr) win[p] = i;
                end
            end
            if (win[p] >= 0 && ((infl[win[p]].ld && win[p] < LR) || (br && win[p] < AR))) haz = 1'b1;
        end
        e.stall = !r && v && haz;
        e.fwd   = 4'b0000;
        for (int p = 0; p < RP; p++) begin
            if (!r && v && !e.stall && win[p] >= 0) e.fwd[p*2 +: 2] = 2'(win[p] + 1);
        end
        e.flush = !r && v && redir && !e.stall;
        e.sc  = sat(stall_ev, 65535);
        e.fc  = sat(fwd_ev, 65535);
        e.ssc = sat(stall_ev, 15);
        e.sfc = sat(fwd_ev, 15);
        expq.push_back(e);
        if (r) begin
            foreach (infl[i]) infl[i].v = 1'b0;
            stall_ev = 0;
            fwd_ev   = 0;
        end else begin
            n.v = v && rw && (rd != 0) && !e.stall;
            n.rd = rd;
            n.ld = ld;
            infl.push_front(n);
            void'(infl.pop_back());
            stall_ev += int'(e.stall);
            fwd_ev   += int'(e.fwd != 4'b0000);
        end
        last_stall = e.stall;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            vectors++;
            if (hif.stall !== me.stall || hif.flush_id !== me.flush || hif.fwd_sel !== me.fwd ||
                int'(hif.stall_count) != me.sc || int'(hif.fwd_count) != me.fc ||
                hsat.stall !== me.stall || hsat.flush_id !== me.flush || hsat.fwd_sel !== me.fwd ||
                int'(hsat.stall_count) != me.ssc || int'(hsat.fwd_count) != me.sfc) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got/exp: stall %b/%b flush %b/%b fwd %h/%h sc %0d/%0d fc %0d/%0d sat_sc %0d/%0d sat_fc %0d/%0d",
                         $time, hif.stall, me.stall, hif.flush_id, me.flush, hif.fwd_sel, me.fwd,
                         hif.stall_count, me.sc, hif.fwd_count, me.fc,
                         hsat.stall_count, me.ssc, hsat.fwd_count, me.sfc);
            end
        end
    end

    initial begin
        ent_t z;
        z.v = 1'b0; z.rd = 0; z.ld = 1'b0;
        for (int i = 0; i < FS; i++) infl.push_back(z);
        rst = 1'b1;
        hif.id_valid = 1'b0; hif.id_rr = '0; hif.id_rr_used = '0; hif.id_regWrite = 1'b0;
        hif.id_regToWrite = '0; hif.id_memRead = 1'b0; hif.id_branch = 1'b0; hif.id_redirect = 1'b0;
        repeat (3) @(posedge clk);

        // ALU producer then consumer on port 0
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 3, 5, 2'b11, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        #2 chk("alu_fwd_sel", int'(hif.fwd_sel), 1); chk("alu_no_stall", int'(hif.stall), 0);
        idle();
        #2 chk("fwd_count_one", int'(hif.fwd_count), 1);
        repeat (2) idle();

        // Load-use: two stall cycles then forward from WB on both ports
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        repeat (2) begin
            apply(1'b0, 1'b1, 3, 3, 2'b11, 1'b1, 4, 1'b0, 1'b0, 1'b0);
            #2 chk("load_use_stall", int'(hif.stall), 1);
        end
        apply(1'b0, 1'b1, 3, 3, 2'b11, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        #2 chk("load_fwd_sel", int'(hif.fwd_sel), 15); chk("load_stall_clear", int'(hif.stall), 0);
        idle();
        #2 chk("stall_count_two", int'(hif.stall_count), 2);
        repeat (2) idle();

        // Youngest match wins; r0 never matches
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 3, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #2 chk("youngest_wins", int'(hif.fwd_sel), 1);
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 0, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #2 chk("r0_no_fwd", int'(hif.fwd_sel), 0); chk("r0_no_stall", int'(hif.stall), 0);
        repeat (3) idle();

        // Branch operand hazard with redirect held under stall
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1, 2, 2'b11, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        #2 chk("branch_stall", int'(hif.stall), 1); chk("branch_no_flush", int'(hif.flush_id), 0);
        apply(1'b0, 1'b1, 1, 2, 2'b11, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        #2 chk("branch_released", int'(hif.stall), 0); chk("branch_fwd_mem", int'(hif.fwd_sel), 2);
        chk("branch_flush", int'(hif.flush_id), 1);
        repeat (3) idle();

        // Mid-run reset with producers in flight
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1, 2, 2'b11, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #2 chk("rst_fwd_zero", int'(hif.fwd_sel), 0); chk("rst_stall_zero", int'(hif.stall), 0);
        apply(1'b0, 1'b1, 1, 2, 2'b11, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #2 chk("post_rst_fwd", int'(hif.fwd_sel), 0); chk("post_rst_stall", int'(hif.stall), 0);
        chk("post_rst_sc", int'(hif.stall_count), 0); chk("post_rst_fc", int'(hif.fwd_count), 0);

        // Twenty stall cycles: the 4-bit counter must pin at 15
        repeat (10) begin
            apply(1'b0, 1'b1, 0, 0, 2'b00, 1'b1, 3, 1'b1, 1'b0, 1'b0);
            repeat (3) apply(1'b0, 1'b1, 3, 0, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        #2 chk("sat_stall_count", int'(hsat.stall_count), 15); chk("wide_stall_count", int'(hif.stall_count), 20);
        repeat (3) idle();

        // Random decode traffic; a stalled instruction is held in ID
        for (int n = 0; n < 3000; n++) begin
            hr = ($urandom_range(99) == 0);
            if (!last_stall || hr) begin
                hv   = ($urandom_range(99) < 85);
                ha0  = $urandom_range(3);
                ha1  = $urandom_range(3);
                hu   = 2'($urandom_range(3));
                hrw  = ($urandom_range(99) < 60);
                hrd  = $urandom_range(3);
                hld  = ($urandom_range(99) < 30);
                hbr  = ($urandom_range(99) < 20);
                hred = ($urandom_range(99) < 20);
            end
            apply(hr, hv, ha0, ha1, hu, hrw, hrd, hld, hbr, hred);
        end
        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
